serial_mag_comparator: RTL and testbench

- Multi-bit magnitude comparator built from a single 1-bit compare cell, applied bit-serially, MSB first.
- Sits directly downstream of the 1-bit comparator stage and uses its three decisions per bit: A<B, A==B, A>B.
- Latches two WIDTH-bit operands on a start pulse and stops at the first differing bit.
- Reports a one-hot registered result with a one-cycle done pulse.

---
 rtl/serial_mag_comparator.sv | 126 ++++++++++++
 tb/tb_serial_mag_comparator.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator: one 1-bit compare cell swept MSB-first over latched operands.
// Latency 1..WIDTH cycles after the accepted start (stops at the first differing bit); start is ignored while busy.
module serial_mag_comparator #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WIDTH-1:0]           a_in,
    input  logic [WIDTH-1:0]           b_in,
    output logic                       busy,
    output logic                       done,
    output logic                       lt,
    output logic                       eq,
    output logic                       gt,
    output logic [$clog2(WIDTH+1)-1:0] bits_used
);

    localparam int BW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [BW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bu_q, bu_d;
    logic             done_q, done_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;

    // Single 1-bit compare cell, always looking at the current MSBs.
    logic bit_a, bit_b, bit_lt, bit_eq, bit_gt;

    assign bit_a  = sa_q[WIDTH-1];
    assign bit_b  = sb_q[WIDTH-1];
    assign bit_lt = ~bit_a & bit_b;
    assign bit_eq = ~(bit_a ^ bit_b);
    assign bit_gt = bit_a & ~bit_b;

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        bu_d    = bu_q;
        done_d  = 1'b0;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a_in;
                    sb_d    = b_in;
                    cnt_d   = BW'(WIDTH - 1);
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    bu_d    = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bit_eq) begin
                    lt_d    = bit_lt;
                    gt_d    = bit_gt;
                    eq_d    = 1'b0;
                    bu_d    = BW'(WIDTH) - cnt_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    eq_d    = 1'b1;
                    bu_d    = BW'(WIDTH);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    // Zero-fill keeps already-examined bits from influencing later steps.
                    sa_d  = sa_q << 1;
                    sb_d  = sb_q << 1;
                    cnt_d = cnt_q - BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            bu_q    <= '0;
            done_q  <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            bu_q    <= bu_d;
            done_q  <= done_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign lt        = lt_q;
    assign eq        = eq_q;
    assign gt        = gt_q;
    assign bits_used = bu_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Self-checking bench for serial_mag_comparator: directed scenarios plus randomized operands
// checked against an arithmetic reference model; a second WIDTH=1 instance covers the single-bit case.
module tb_serial_mag_comparator;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy, done, lt, eq, gt;
    logic [3:0]   bits_used;

    logic         start1 = 1'b0;
    logic [0:0]   a1 = '0;
    logic [0:0]   b1 = '0;
    logic         busy1, done1, lt1, eq1, gt1;
    logic [0:0]   bu1;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    serial_mag_comparator #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .lt(lt), .eq(eq), .gt(gt), .bits_used(bits_used)
    );

    serial_mag_comparator #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1),
        .busy(busy1), .done(done1), .lt(lt1), .eq(eq1), .gt(gt1), .bits_used(bu1)
    );

    // Reference: the result is plain magnitude order; the latency is set by the highest differing bit.
    function automatic void ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output bit elt, output bit eeq, output bit egt, output int elat);
        int diff;
        diff = int'(a ^ b);
        elt  = (a < b);
        eeq  = (a == b);
        egt  = (a > b);
        if (diff == 0) elat = W;
        else           elat = W - ($clog2(diff + 1) - 1);
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done, scrambling the operand inputs each cycle; lat counts edges from entry (-1 on timeout).
    task automatic wait_done(output int lat, output bit busy_ok, output bit clr_ok);
        lat     = -1;
        busy_ok = 1'b1;
        clr_ok  = 1'b1;
        for (int k = 0; k <= W + 4; k++) begin
            if (done === 1'b1) begin
                lat = k;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if ((lt | eq | gt) !== 1'b0) clr_ok = 1'b0;
            a_in = W'($urandom);
            b_in = W'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if ({busy, done, lt, eq, gt, bits_used} !== 9'd0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %b expected 0", {busy, done, lt, eq, gt, bits_used});
        end
        vec_cnt++;
        if ({busy1, done1, lt1, eq1, gt1, bu1} !== 6'd0) begin
            err_cnt++;
            $display("FAIL reset_outputs_w1: got %b expected 0", {busy1, done1, lt1, eq1, gt1, bu1});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_bit_diff();
        int lat; bit bok, cok;
        start_op(8'hA5, 8'h25);
        wait_done(lat, bok, cok);
        vec_cnt++;
        if (lat !== 1) begin err_cnt++; $display("FAIL msb_latency: got %0d expected 1", lat); end
        vec_cnt++;
        if ({lt, eq, gt} !== 3'b001) begin err_cnt++; $display("FAIL msb_result: got %b expected 001", {lt, eq, gt}); end
        vec_cnt++;
        if (bits_used !== 4'd1) begin err_cnt++; $display("FAIL msb_bits_used: got %0d expected 1", bits_used); end
        vec_cnt++;
        if (!bok) begin err_cnt++; $display("FAIL msb_busy: got bad busy window expected 1 cycle"); end
    endtask

    // Entered at the negedge where done=1 from the previous comparison.
    task automatic test_back_to_back();
        int lat; bit bok, cok;
        start_op(8'h01, 8'h02);
        vec_cnt++;
        if ({busy, done} !== 2'b10) begin err_cnt++; $display("FAIL b2b_accept: got busy,done=%b expected 10", {busy, done}); end
        wait_done(lat, bok, cok);
        vec_cnt++;
        if (lat !== 7) begin err_cnt++; $display("FAIL b2b_latency: got %0d expected 7", lat); end
        vec_cnt++;
        if ({lt, eq, gt, bits_used} !== {3'b100, 4'd7}) begin
            err_cnt++; $display("FAIL b2b_result: got %b/%0d expected 100/7", {lt, eq, gt}, bits_used);
        end
        vec_cnt++;
        if (!cok) begin err_cnt++; $display("FAIL b2b_clear: got nonzero result during run expected 000"); end
        @(negedge clk);
    endtask

    task automatic test_lsb_diff();
        int lat; bit bok, cok;
        start_op(8'h3C, 8'h3D);
        wait_done(lat, bok, cok);
        vec_cnt++;
        if (lat !== 8) begin err_cnt++; $display("FAIL lsb_latency: got %0d expected 8", lat); end
        vec_cnt++;
        if ({lt, eq, gt, bits_used} !== {3'b100, 4'd8}) begin
            err_cnt++; $display("FAIL lsb_result: got %b/%0d expected 100/8", {lt, eq, gt}, bits_used);
        end
        vec_cnt++;
        if (!bok) begin err_cnt++; $display("FAIL lsb_busy: got bad busy window expected 8 cycles"); end
        @(negedge clk);
    endtask

    task automatic test_equal();
        int lat; bit bok, cok;
        start_op(8'h5A, 8'h5A);
        wait_done(lat, bok, cok);
        vec_cnt++;
        if (lat !== 8) begin err_cnt++; $display("FAIL eq_latency: got %0d expected 8", lat); end
        vec_cnt++;
        if ({lt, eq, gt, bits_used} !== {3'b010, 4'd8}) begin
            err_cnt++; $display("FAIL eq_result: got %b/%0d expected 010/8", {lt, eq, gt}, bits_used);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec_cnt++;
            if ({done, lt, eq, gt, bits_used} !== {4'b0010, 4'd8}) begin
                err_cnt++; $display("FAIL eq_hold: got %b/%0d expected 0010/8", {done, lt, eq, gt}, bits_used);
            end
        end
    endtask

    task automatic test_start_ignored();
        int lat; bit bok, cok;
        start_op(8'h10, 8'h18);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; a_in = 8'hFF; b_in = 8'h00;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bok, cok);
        vec_cnt++;
        if (lat !== 2) begin err_cnt++; $display("FAIL busy_start_latency: got %0d expected 2 more (5 total)", lat); end
        vec_cnt++;
        if ({lt, eq, gt, bits_used} !== {3'b100, 4'd5}) begin
            err_cnt++; $display("FAIL busy_start_result: got %b/%0d expected 100/5", {lt, eq, gt}, bits_used);
        end
        @(negedge clk);
        vec_cnt++;
        if (busy !== 1'b0) begin err_cnt++; $display("FAIL busy_start_relaunch: got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_abort();
        int lat; bit bok, cok, saw_done;
        start_op(8'h3C, 8'h3D);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({busy, done, lt, eq, gt, bits_used} !== 9'd0) begin
            err_cnt++; $display("FAIL abort_outputs: got %b expected 0", {busy, done, lt, eq, gt, bits_used});
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        vec_cnt++;
        if (saw_done) begin err_cnt++; $display("FAIL abort_no_done: got done/busy after abort expected none"); end
        start_op(8'h80, 8'h00);
        wait_done(lat, bok, cok);
        vec_cnt++;
        if (lat !== 1 || {lt, eq, gt, bits_used} !== {3'b001, 4'd1}) begin
            err_cnt++; $display("FAIL abort_restart: got lat=%0d %b/%0d expected lat=1 001/1", lat, {lt, eq, gt}, bits_used);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, hlt_snap;
        bit elt, eeq, egt, bok, cok;
        int elat, lat, idle;
        for (int n = 0; n < 40; n++) begin
            a = W'($urandom);
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ (W'(1) << $urandom_range(0, W - 1));
                default: b = W'($urandom);
            endcase
            ref_cmp(a, b, elt, eeq, egt, elat);
            start_op(a, b);
            wait_done(lat, bok, cok);
            vec_cnt++;
            if (lat !== elat) begin err_cnt++; $display("FAIL rnd_latency a=%h b=%h: got %0d expected %0d", a, b, lat, elat); end
            vec_cnt++;
            if ({lt, eq, gt} !== {elt, eeq, egt}) begin
                err_cnt++; $display("FAIL rnd_result a=%h b=%h: got %b expected %b", a, b, {lt, eq, gt}, {elt, eeq, egt});
            end
            vec_cnt++;
            if (int'(bits_used) !== elat) begin
                err_cnt++; $display("FAIL rnd_bits_used a=%h b=%h: got %0d expected %0d", a, b, bits_used, elat);
            end
            vec_cnt++;
            if (!bok || !cok) begin err_cnt++; $display("FAIL rnd_run_window a=%h b=%h: got busy_ok=%0d clr_ok=%0d expected 1,1", a, b, bok, cok); end
            idle = $urandom_range(0, 2);
            hlt_snap = {5'd0, elt, eeq, egt};
            for (int i = 0; i < idle; i++) begin
                @(negedge clk);
                vec_cnt++;
                if ({done, lt, eq, gt} !== {1'b0, hlt_snap[2:0]}) begin
                    err_cnt++; $display("FAIL rnd_hold: got %b expected %b", {done, lt, eq, gt}, {1'b0, hlt_snap[2:0]});
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_width1();
        logic ea, eb;
        for (int n = 0; n < 8; n++) begin
            ea = n[0];
            eb = n[1] ^ $urandom_range(0, 1) ;
            start1 = 1'b1; a1 = ea; b1 = eb;
            @(posedge clk);
            @(negedge clk);
            start1 = 1'b0;
            a1 = ~ea; b1 = ~eb;
            vec_cnt++;
            if ({busy1, done1} !== 2'b10) begin err_cnt++; $display("FAIL w1_busy: got %b expected 10", {busy1, done1}); end
            @(negedge clk);
            vec_cnt++;
            if ({busy1, done1, lt1, eq1, gt1, bu1} !== {2'b01, (ea < eb), (ea == eb), (ea > eb), 1'b1}) begin
                err_cnt++;
                $display("FAIL w1_result a=%b b=%b: got %b expected %b", ea, eb, {busy1, done1, lt1, eq1, gt1, bu1},
                         {2'b01, (ea < eb), (ea == eb), (ea > eb), 1'b1});
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_bit_diff();
        test_back_to_back();
        test_lsb_diff();
        test_equal();
        test_start_ignored();
        test_reset_abort();
        test_random();
        test_width1();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
